// File: rtl/mem_access_unit.sv
// mem_access_unit: single-port memory access sequencer.
// Accepts word/byte loads and stores plus one-level indirect load/store
// (LDI/STI) and drives a request/response style memory port. All outputs
// are registered; the unit waits indefinitely for mem_resp.

module mem_access_unit #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [AWIDTH-1:0]      req_addr,
  input  logic [WIDTH-1:0]       req_wdata,
  output logic                   resp_valid,
  output logic [WIDTH-1:0]       resp_rdata,
  output logic                   resp_err,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [AWIDTH-1:0]      mem_address,
  output logic [WIDTH-1:0]       mem_wdata,
  output logic [WIDTH/8-1:0]     mem_byte_enable,
  input  logic [WIDTH-1:0]       mem_rdata,
  input  logic                   mem_resp
);

  localparam int NB = WIDTH / 8;
  localparam int LB = $clog2(NB);

  localparam logic [2:0] OP_LDW = 3'b000;
  localparam logic [2:0] OP_LDB = 3'b001;
  localparam logic [2:0] OP_STW = 3'b010;
  localparam logic [2:0] OP_STB = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;
  localparam logic [2:0] OP_STI = 3'b101;

  // Clears the byte-offset bits of an address.
  localparam logic [AWIDTH-1:0] ALIGN_MASK = {{(AWIDTH-LB){1'b1}}, {LB{1'b0}}};
  localparam logic [NB-1:0]     BE_ALL     = {NB{1'b1}};
  localparam logic [WIDTH-1:0]  ZERO_WORD  = {WIDTH{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [AWIDTH-1:0] word_align(input logic [AWIDTH-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  function automatic logic [NB-1:0] lane_onehot(input logic [LB-1:0] lane);
    logic [NB-1:0] one;
    one = {{(NB-1){1'b0}}, 1'b1};
    return one << lane;
  endfunction

  function automatic logic [WIDTH-1:0] byte_extract(input logic [WIDTH-1:0] w,
                                                    input logic [LB-1:0]    lane);
    logic [7:0] b;
    b = w[{lane, 3'b000} +: 8];
    return {{(WIDTH-8){1'b0}}, b};
  endfunction

  function automatic logic is_byte_op(input logic [2:0] op);
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [LB-1:0]       lane_q, lane_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [AWIDTH-1:0]   mem_address_q, mem_address_d;
  logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]       mem_be_q, mem_be_d;
  logic                resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  // Pointer fetched by LDI/STI, resized to the address width and word aligned.
  logic [AWIDTH-1:0]   ptr_s;
  assign ptr_s = word_align(AWIDTH'(mem_rdata));

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = resp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          lane_d  = req_addr[LB-1:0];
          wdata_d = req_wdata;
          case (req_op)
            OP_LDW, OP_LDB, OP_LDI, OP_STI: begin
              state_d       = S_RD1;
              mem_read_d    = 1'b1;
              mem_address_d = is_byte_op(req_op) ? req_addr : word_align(req_addr);
              mem_be_d      = is_byte_op(req_op) ? lane_onehot(req_addr[LB-1:0]) : BE_ALL;
            end
            OP_STW, OP_STB: begin
              state_d       = S_WR;
              mem_write_d   = 1'b1;
              mem_address_d = is_byte_op(req_op) ? req_addr : word_align(req_addr);
              mem_be_d      = is_byte_op(req_op) ? lane_onehot(req_addr[LB-1:0]) : BE_ALL;
              mem_wdata_d   = is_byte_op(req_op) ? {NB{req_wdata[7:0]}} : req_wdata;
            end
            default: begin
              // Illegal opcode: answer with an error, never touch memory.
              state_d      = S_RESP;
              resp_valid_d = 1'b1;
              resp_err_d   = 1'b1;
              resp_rdata_d = ZERO_WORD;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RD1: begin
        if (mem_resp) begin
          case (op_q)
            OP_LDB: begin
              state_d      = S_RESP;
              mem_read_d   = 1'b0;
              resp_valid_d = 1'b1;
              resp_rdata_d = byte_extract(mem_rdata, lane_q);
            end
            OP_LDI: begin
              // Read stays asserted, now aimed at the fetched pointer.
              state_d       = S_RD2;
              mem_read_d    = 1'b1;
              mem_address_d = ptr_s;
              mem_be_d      = BE_ALL;
            end
            OP_STI: begin
              state_d       = S_WR;
              mem_read_d    = 1'b0;
              mem_write_d   = 1'b1;
              mem_address_d = ptr_s;
              mem_be_d      = BE_ALL;
              mem_wdata_d   = wdata_q;
            end
            default: begin
              state_d      = S_RESP;
              mem_read_d   = 1'b0;
              resp_valid_d = 1'b1;
              resp_rdata_d = mem_rdata;
            end
          endcase
        end else begin
          state_d = S_RD1;
        end
      end

      S_RD2: begin
        if (mem_resp) begin
          state_d      = S_RESP;
          mem_read_d   = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_rdata;
        end else begin
          state_d = S_RD2;
        end
      end

      S_WR: begin
        if (mem_resp) begin
          state_d      = S_RESP;
          mem_write_d  = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = ZERO_WORD;
        end else begin
          state_d = S_WR;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // Sequencer state and registered outputs, synchronous reset has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= 3'b000;
      lane_q        <= {LB{1'b0}};
      wdata_q       <= ZERO_WORD;
      req_ready_q   <= 1'b1;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= {AWIDTH{1'b0}};
      mem_wdata_q   <= ZERO_WORD;
      mem_be_q      <= {NB{1'b0}};
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= ZERO_WORD;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      req_ready_q   <= req_ready_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_err        = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (WIDTH=16, AWIDTH=16).
// Expected responses are queued when a request is accepted and compared when
// resp_valid appears; the bench also plays the memory and checks each access.

module tb_mem_access_unit;

  localparam int WIDTH  = 16;
  localparam int AWIDTH = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                req_valid;
  logic                req_ready;
  logic [2:0]          req_op;
  logic [AWIDTH-1:0]   req_addr;
  logic [WIDTH-1:0]    req_wdata;
  logic                resp_valid;
  logic [WIDTH-1:0]    resp_rdata;
  logic                resp_err;
  logic                mem_read;
  logic                mem_write;
  logic [AWIDTH-1:0]   mem_address;
  logic [WIDTH-1:0]    mem_wdata;
  logic [1:0]          mem_byte_enable;
  logic [WIDTH-1:0]    mem_rdata;
  logic                mem_resp;

  mem_access_unit #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_read || mem_write)
      chk_eq("rw_exclusive", 64'(mem_read & mem_write), 64'd0);
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        chk_eq("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk_eq("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
        chk_eq("resp_err",   64'(resp_err),   64'(e.err));
        chk_eq("resp_latency", 64'(int'(cyc) - e.t_acc + 1), 64'(e.lat));
      end
    end
  end

  // Offer one request, wait for acceptance, then scramble the request inputs.
  task automatic do_req(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input bit track);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk_eq("ready_before_req", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    if (track) sb_q.push_back('{exp_rdata, exp_err, exp_lat, int'(cyc)});
  endtask

  // Act as memory for one access: check it, stall 'waits' cycles, then respond.
  task automatic serve(input string tag, input bit is_wr, input logic [15:0] exp_addr,
                       input logic [1:0] exp_be, input logic [15:0] exp_wdata,
                       input logic [15:0] rdata, input int waits);
    int n = 0;
    @(negedge clk);
    while (!(mem_read || mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_eq({tag, "_seen"}, 64'(mem_read | mem_write), 64'd1);
    chk_eq({tag, "_kind"}, 64'({mem_write, mem_read}), is_wr ? 64'd2 : 64'd1);
    chk_eq({tag, "_addr"}, 64'(mem_address), 64'(exp_addr));
    chk_eq({tag, "_be"},   64'(mem_byte_enable), 64'(exp_be));
    if (is_wr) chk_eq({tag, "_wdata"}, 64'(mem_wdata), 64'(exp_wdata));
    chk_eq({tag, "_busy"}, 64'(req_ready), 64'd0);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      chk_eq({tag, "_hold"}, 64'({mem_write, mem_read, mem_address, mem_byte_enable}),
             64'({is_wr, ~is_wr, exp_addr, exp_be}));
      if (is_wr) chk_eq({tag, "_hold_wdata"}, 64'(mem_wdata), 64'(exp_wdata));
    end
    mem_resp  = 1'b1;
    mem_rdata = rdata;
    @(posedge clk); #1;
    mem_resp  = 1'b0;
    mem_rdata = 16'($urandom);
  endtask

  // Response cycle and the cycle after it: pulse width, idle bus, held data.
  task automatic finish_op(input string tag, input logic [15:0] exp_rdata);
    @(negedge clk);
    chk_eq({tag, "_resp_pulse"}, 64'(resp_valid), 64'd1);
    chk_eq({tag, "_bus_idle"}, 64'({mem_read, mem_write}), 64'd0);
    @(negedge clk);
    chk_eq({tag, "_resp_drop"}, 64'(resp_valid), 64'd0);
    chk_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
    chk_eq({tag, "_bus_idle2"}, 64'({mem_read, mem_write}), 64'd0);
    chk_eq({tag, "_rdata_hold"}, 64'(resp_rdata), 64'(exp_rdata));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin : main
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
    mem_rdata = 16'h0000;
    mem_resp  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_ready", 64'(req_ready), 64'd1);
    chk_eq("rst_ctrl", 64'({mem_read, mem_write, resp_valid, resp_err}), 64'd0);
    chk_eq("rst_mem_addr", 64'(mem_address), 64'd0);
    chk_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk_eq("rst_be", 64'(mem_byte_enable), 64'd0);
    chk_eq("rst_rdata", 64'(resp_rdata), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // LDB, lane 1, immediate response.
    do_req(3'b001, 16'h3005, 16'h0000, 16'h00A5, 1'b0, 2, 1'b1);
    serve("ldb", 1'b0, 16'h3005, 2'b10, 16'h0000, 16'hA55A, 0);
    finish_op("ldb", 16'h00A5);

    // LDW, unaligned address, one wait cycle.
    do_req(3'b000, 16'h1235, 16'h0000, 16'h1357, 1'b0, 3, 1'b1);
    serve("ldw", 1'b0, 16'h1234, 2'b11, 16'h0000, 16'h1357, 1);
    finish_op("ldw", 16'h1357);

    // STB, lane 0, three wait cycles.
    do_req(3'b011, 16'h2000, 16'h12C3, 16'h0000, 1'b0, 5, 1'b1);
    serve("stb", 1'b1, 16'h2000, 2'b01, 16'hC3C3, 16'h0000, 3);
    finish_op("stb", 16'h0000);

    // STW, unaligned address.
    do_req(3'b010, 16'h2003, 16'hA1B2, 16'h0000, 1'b0, 2, 1'b1);
    serve("stw", 1'b1, 16'h2002, 2'b11, 16'hA1B2, 16'h0000, 0);
    finish_op("stw", 16'h0000);

    // LDI: pointer fetch then aligned data read.
    do_req(3'b100, 16'h4001, 16'h0000, 16'hBEEF, 1'b0, 3, 1'b1);
    serve("ldi_ptr", 1'b0, 16'h4000, 2'b11, 16'h0000, 16'h5003, 0);
    serve("ldi_dat", 1'b0, 16'h5002, 2'b11, 16'h0000, 16'hBEEF, 0);
    finish_op("ldi", 16'hBEEF);

    // STI: pointer fetch (one wait) then word write at the pointer.
    do_req(3'b101, 16'h0100, 16'h7777, 16'h0000, 1'b0, 4, 1'b1);
    serve("sti_ptr", 1'b0, 16'h0100, 2'b11, 16'h0000, 16'h0200, 1);
    serve("sti_wr", 1'b1, 16'h0200, 2'b11, 16'h7777, 16'h0000, 0);
    finish_op("sti", 16'h0000);

    // LDB lane 0, restores a non-zero held value before the error cases.
    do_req(3'b001, 16'h3004, 16'h0000, 16'h005A, 1'b0, 2, 1'b1);
    serve("ldb0", 1'b0, 16'h3004, 2'b01, 16'h0000, 16'hA55A, 0);
    finish_op("ldb0", 16'h005A);

    // Illegal opcodes: error response at T+1, memory untouched.
    do_req(3'b111, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1, 1'b1);
    finish_op("ill7", 16'h0000);
    do_req(3'b110, 16'h3333, 16'h4444, 16'h0000, 1'b1, 1, 1'b1);
    finish_op("ill6", 16'h0000);

    // mem_resp while idle is ignored.
    @(negedge clk);
    mem_resp  = 1'b1;
    mem_rdata = 16'hDEAD;
    repeat (2) @(negedge clk);
    chk_eq("idle_resp_ignored", 64'({resp_valid, mem_read, mem_write}), 64'd0);
    chk_eq("idle_resp_ready", 64'(req_ready), 64'd1);
    mem_resp = 1'b0;
    @(posedge clk); #1;

    // Reset during an RD1 wait aborts the load without a response.
    do_req(3'b000, 16'h6000, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk_eq("abort_read_up", 64'(mem_read), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_eq("abort_read_low", 64'(mem_read), 64'd0);
    chk_eq("abort_no_resp", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk_eq("abort_ready", 64'(req_ready), 64'd1);
    chk_eq("abort_bus_idle", 64'({mem_read, mem_write}), 64'd0);
    repeat (3) @(negedge clk);

    // Unit still works after the abort.
    @(posedge clk); #1;
    do_req(3'b000, 16'h7777, 16'h0000, 16'hC0DE, 1'b0, 2, 1'b1);
    serve("post_rst", 1'b0, 16'h7776, 2'b11, 16'h0000, 16'hC0DE, 0);
    finish_op("post_rst", 16'hC0DE);

    repeat (3) @(negedge clk);
    chk_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
